// File: rtl/alu.sv
// 32-bit RV32I integer ALU with a registered result (one cycle of latency).
// Operation select is {funct7[5], funct3}. Undefined codes produce 0.
// Optional macro ALU_FLAGS_EN adds registered Zero/Negative/Carry/Overflow outputs.
module alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUOp,
    output logic [WIDTH-1:0] ALURes
`ifdef ALU_FLAGS_EN
    ,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry,
    output logic             Overflow
`endif
);

    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpSub  = 4'b1000;
    localparam logic [3:0] OpSll  = 4'b0001;
    localparam logic [3:0] OpSlt  = 4'b0010;
    localparam logic [3:0] OpSltu = 4'b0011;
    localparam logic [3:0] OpXor  = 4'b0100;
    localparam logic [3:0] OpSrl  = 4'b0101;
    localparam logic [3:0] OpSra  = 4'b1101;
    localparam logic [3:0] OpOr   = 4'b0110;
    localparam logic [3:0] OpAnd  = 4'b0111;

    logic [4:0]              w_shamt;
    logic [WIDTH-1:0]        w_add;
    logic [WIDTH-1:0]        w_sub;
    logic                    w_slt;
    logic                    w_sltu;
    logic signed [WIDTH-1:0] w_sra;
    logic [WIDTH-1:0]        w_res;
    logic [WIDTH-1:0]        r_res;

    // Only the low five bits of B select the shift distance.
    assign w_shamt = B[4:0];

`ifdef ALU_FLAGS_EN
    logic [WIDTH:0] w_add_ext;
    logic [WIDTH:0] w_sub_ext;

    // Extended sums expose the carry-out; subtraction as A + ~B + 1 so that
    // bit WIDTH is the not-borrow (A >= B unsigned).
    assign w_add_ext = {1'b0, A} + {1'b0, B};
    assign w_sub_ext = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
    assign w_add     = w_add_ext[WIDTH-1:0];
    assign w_sub     = w_sub_ext[WIDTH-1:0];
`else
    assign w_add = A + B;
    assign w_sub = A - B;
`endif

    assign w_slt  = ($signed(A) < $signed(B));
    assign w_sltu = (A < B);
    assign w_sra  = $signed(A) >>> w_shamt;

    // Decode the operation into the next result value.
    always_comb begin
        w_res = '0;
        case (ALUOp)
            OpAdd:   w_res = w_add;
            OpSub:   w_res = w_sub;
            OpSll:   w_res = A << w_shamt;
            OpSlt:   w_res = {{(WIDTH-1){1'b0}}, w_slt};
            OpSltu:  w_res = {{(WIDTH-1){1'b0}}, w_sltu};
            OpXor:   w_res = A ^ B;
            OpSrl:   w_res = A >> w_shamt;
            OpSra:   w_res = w_sra;
            OpOr:    w_res = A | B;
            OpAnd:   w_res = A & B;
            default: w_res = '0;
        endcase
    end

    // Result register; reset wins over any operation in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_res <= '0;
        end else begin
            r_res <= w_res;
        end
    end

    assign ALURes = r_res;

`ifdef ALU_FLAGS_EN
    logic w_zero;
    logic w_neg;
    logic w_carry;
    logic w_ovf;
    logic r_zero;
    logic r_neg;
    logic r_carry;
    logic r_ovf;

    // Flags derive from the same next result; carry/overflow only for ADD/SUB.
    always_comb begin
        w_zero  = (w_res == '0);
        w_neg   = w_res[WIDTH-1];
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        if (ALUOp == OpAdd) begin
            w_carry = w_add_ext[WIDTH];
            w_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (w_add[WIDTH-1] != A[WIDTH-1]);
        end else if (ALUOp == OpSub) begin
            w_carry = w_sub_ext[WIDTH];
            w_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (w_sub[WIDTH-1] != A[WIDTH-1]);
        end
    end

    // Flag registers share the result's latency and reset behaviour.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_zero  <= w_zero;
            r_neg   <= w_neg;
            r_carry <= w_carry;
            r_ovf   <= w_ovf;
        end
    end

    assign Zero     = r_zero;
    assign Negative = r_neg;
    assign Carry    = r_carry;
    assign Overflow = r_ovf;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: table of directed vectors plus reset sequences.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUOp;
    logic [31:0] ALURes;
`ifdef ALU_FLAGS_EN
    logic        Zero;
    logic        Negative;
    logic        Carry;
    logic        Overflow;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        c;
        logic        v;
    } vec_t;

    vec_t vecs[$];

    alu #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (A),
        .B       (B),
        .ALUOp   (ALUOp),
        .ALURes  (ALURes)
`ifdef ALU_FLAGS_EN
        ,
        .Zero    (Zero),
        .Negative(Negative),
        .Carry   (Carry),
        .Overflow(Overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input logic c, input logic v);
        vec_t t;
        t.op = op; t.a = a; t.b = b; t.exp = exp; t.c = c; t.v = v;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic rst, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        rst_n = rst; ALUOp = op; A = a; B = b;
    endtask

    // Wait for the active edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string name, input logic z, input logic n,
                               input logic c, input logic v);
`ifdef ALU_FLAGS_EN
        check({name, ".zero"}, {31'b0, Zero},     {31'b0, z});
        check({name, ".neg"},  {31'b0, Negative}, {31'b0, n});
        check({name, ".carry"},{31'b0, Carry},    {31'b0, c});
        check({name, ".ovf"},  {31'b0, Overflow}, {31'b0, v});
`else
        if (z || n || c || v) begin end
`endif
    endtask

    initial begin
        // op, A, B, expected, carry, overflow
        add(4'b0000, 32'd10,        32'd5,         32'd15,        1'b0, 1'b0);
        add(4'b1000, 32'd10,        32'd5,         32'd5,         1'b1, 1'b0);
        add(4'b0000, 32'h7FFFFFFF,  32'd1,         32'h80000000,  1'b0, 1'b1);
        add(4'b1000, 32'd0,         32'd1,         32'hFFFFFFFF,  1'b0, 1'b0);
        add(4'b1000, 32'h80000000,  32'd1,         32'h7FFFFFFF,  1'b1, 1'b1);
        add(4'b0000, 32'hFFFFFFFF,  32'd1,         32'h00000000,  1'b1, 1'b0);
        add(4'b1000, 32'd5,         32'd5,         32'h00000000,  1'b1, 1'b0);
        add(4'b0111, 32'hF0F0F0F0,  32'h0F0F0F0F,  32'h00000000,  1'b0, 1'b0);
        add(4'b0110, 32'hF0F0F0F0,  32'h0F0F0F0F,  32'hFFFFFFFF,  1'b0, 1'b0);
        add(4'b0100, 32'hF0F0F0F0,  32'hFFFF0000,  32'h0F0FF0F0,  1'b0, 1'b0);
        add(4'b0010, 32'd10,        32'd20,        32'd1,         1'b0, 1'b0);
        add(4'b0010, 32'd20,        32'd10,        32'd0,         1'b0, 1'b0);
        add(4'b0010, 32'hFFFFFFFF,  32'd1,         32'd1,         1'b0, 1'b0);
        add(4'b0011, 32'hFFFFFFFF,  32'd1,         32'd0,         1'b0, 1'b0);
        add(4'b0010, 32'd7,         32'd7,         32'd0,         1'b0, 1'b0);
        add(4'b0011, 32'd1,         32'hFFFFFFFF,  32'd1,         1'b0, 1'b0);
        add(4'b0010, 32'h80000000,  32'd1,         32'd1,         1'b0, 1'b0);
        add(4'b0011, 32'h80000000,  32'd1,         32'd0,         1'b0, 1'b0);
        add(4'b0001, 32'd1,         32'd4,         32'h00000010,  1'b0, 1'b0);
        add(4'b0101, 32'hF0000000,  32'd4,         32'h0F000000,  1'b0, 1'b0);
        add(4'b1101, 32'hF0000000,  32'd4,         32'hFF000000,  1'b0, 1'b0);
        add(4'b0001, 32'd1,         32'h24,        32'h00000010,  1'b0, 1'b0);
        add(4'b1101, 32'h80000000,  32'd31,        32'hFFFFFFFF,  1'b0, 1'b0);
        add(4'b0101, 32'h80000000,  32'd31,        32'h00000001,  1'b0, 1'b0);
        add(4'b1101, 32'h70000000,  32'd4,         32'h07000000,  1'b0, 1'b0);
        add(4'b0001, 32'h12345678,  32'd0,         32'h12345678,  1'b0, 1'b0);
        add(4'b0101, 32'h12345678,  32'd32,        32'h12345678,  1'b0, 1'b0);
        add(4'b1111, 32'd5,         32'd5,         32'd0,         1'b0, 1'b0);
        add(4'b1001, 32'd3,         32'd4,         32'd0,         1'b0, 1'b0);
        add(4'b1010, 32'd3,         32'd4,         32'd0,         1'b0, 1'b0);
        add(4'b1011, 32'hFFFFFFFF,  32'd4,         32'd0,         1'b0, 1'b0);
        add(4'b1100, 32'd3,         32'd4,         32'd0,         1'b0, 1'b0);
        add(4'b1110, 32'd3,         32'd4,         32'd0,         1'b0, 1'b0);

        // Reset held for two edges with a live ADD on the inputs.
        drive(1'b0, 4'b0000, 32'd10, 32'd5);
        tick();
        check("reset_edge1", ALURes, 32'd0);
        check_flags("reset_edge1", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("reset_edge2", ALURes, 32'd0);
        rst_n = 1'b1;
        tick();
        check("reset_release", ALURes, 32'd15);

        // Table: one op per cycle; also confirm the output holds until the edge.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            #1;
            if (i > 0) check($sformatf("hold%0d", i), ALURes, vecs[i-1].exp);
            tick();
            check($sformatf("vec%0d", i), ALURes, vecs[i].exp);
            check_flags($sformatf("vec%0d", i), (vecs[i].exp == 32'd0), vecs[i].exp[31],
                        vecs[i].c, vecs[i].v);
        end

        // Reset mid-stream discards the in-flight SUB.
        drive(1'b1, 4'b0000, 32'd10, 32'd5);
        tick();
        check("mid_pre", ALURes, 32'd15);
        drive(1'b0, 4'b1000, 32'hFFFFFFFF, 32'd1);
        tick();
        check("mid_reset", ALURes, 32'd0);
        check_flags("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'b0000, 32'd1, 32'd2);
        #1;
        check("mid_hold", ALURes, 32'd0);
        tick();
        check("mid_first", ALURes, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
